// File: rtl/dpsk_bit_tx.sv
// DPSK transmit bit timing: serializes bytes MSB-first, one differentially encoded symbol
// every BIT_DIV clocks. Define DPSK_TX_PREAMBLE_EN to prefix each burst with raw-1 symbols.
module dpsk_bit_tx #(
    parameter int unsigned BIT_DIV      = 217391,
    parameter int unsigned PREAMBLE_LEN = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dpsk_tx_data,
    output logic       dpsk_tx_raw,
    output logic       dpsk_tx_strobe,
    output logic       tx_busy
);

    localparam int unsigned CNT_W = $clog2(BIT_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BIT_DIV - 1);

    if (BIT_DIV < 2 || PREAMBLE_LEN < 1) begin : g_bad_param
        $error("dpsk_bit_tx: BIT_DIV must be >= 2 and PREAMBLE_LEN >= 1");
    end

`ifdef DPSK_TX_PREAMBLE_EN
    localparam int unsigned PRE_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);

    typedef enum logic [1:0] {StIdle, StPreamble, StShift} state_t;

    logic [PRE_W-1:0] r_pre_cnt, w_pre_cnt_nxt;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_t;
`endif

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [CNT_W-1:0] r_div_cnt, w_div_cnt_nxt;
    logic             r_data, w_data_nxt;
    logic             r_raw, w_raw_nxt;
    logic             r_strobe, w_strobe_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_div_last, w_byte_last, w_accept;
    logic             w_sym_start, w_sym_bit;

    assign w_div_last  = (r_div_cnt == DIV_LAST);
    assign w_byte_last = (r_state == StShift) && (r_bit_cnt == 3'd7) && w_div_last;
    assign tx_ready    = !rst && ((r_state == StIdle) || w_byte_last);
    assign w_accept    = tx_valid && tx_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_div_cnt_nxt = w_div_last ? '0 : r_div_cnt + 1'b1;
        w_busy_nxt    = r_busy;
        w_sym_start   = 1'b0;
        w_sym_bit     = 1'b0;
`ifdef DPSK_TX_PREAMBLE_EN
        w_pre_cnt_nxt = r_pre_cnt;
`endif
        unique case (r_state)
            StIdle: begin
                w_div_cnt_nxt = '0;
                if (w_accept) begin
                    w_bit_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_sym_start   = 1'b1;
`ifdef DPSK_TX_PREAMBLE_EN
                    w_state_nxt   = StPreamble;
                    w_shift_nxt   = tx_data;
                    w_pre_cnt_nxt = '0;
                    w_sym_bit     = 1'b1;
`else
                    w_state_nxt   = StShift;
                    w_shift_nxt   = {tx_data[6:0], 1'b0};
                    w_sym_bit     = tx_data[7];
`endif
                end
            end
`ifdef DPSK_TX_PREAMBLE_EN
            StPreamble: begin
                if (w_div_last) begin
                    w_sym_start = 1'b1;
                    if (r_pre_cnt == PRE_LAST) begin
                        w_state_nxt   = StShift;
                        w_sym_bit     = r_shift[7];
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_pre_cnt_nxt = r_pre_cnt + 1'b1;
                        w_sym_bit     = 1'b1;
                    end
                end
            end
`endif
            StShift: begin
                if (w_div_last) begin
                    if (r_bit_cnt == 3'd7) begin
                        // Back-to-back byte: continue without a gap or preamble
                        if (w_accept) begin
                            w_sym_start   = 1'b1;
                            w_sym_bit     = tx_data[7];
                            w_shift_nxt   = {tx_data[6:0], 1'b0};
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = StIdle;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_sym_start   = 1'b1;
                        w_sym_bit     = r_shift[7];
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        w_strobe_nxt = w_sym_start;
        w_raw_nxt    = w_sym_start ? w_sym_bit : r_raw;
        w_data_nxt   = w_sym_start ? (w_sym_bit ^ r_data) : r_data;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_data    <= 1'b0;
            r_raw     <= 1'b0;
            r_strobe  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef DPSK_TX_PREAMBLE_EN
            r_pre_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_data    <= w_data_nxt;
            r_raw     <= w_raw_nxt;
            r_strobe  <= w_strobe_nxt;
            r_busy    <= w_busy_nxt;
`ifdef DPSK_TX_PREAMBLE_EN
            r_pre_cnt <= w_pre_cnt_nxt;
`endif
        end
    end

    assign dpsk_tx_data   = r_data;
    assign dpsk_tx_raw    = r_raw;
    assign dpsk_tx_strobe = r_strobe;
    assign tx_busy        = r_busy;

endmodule

// File: tb/tb_dpsk_bit_tx.sv
// Self-checking bench for dpsk_bit_tx: per-cycle reference model plus directed byte vectors.
// Honours DPSK_TX_PREAMBLE_EN when compiled with it.
module tb_dpsk_bit_tx;

    localparam int BIT_DIV      = 4;
    localparam int PREAMBLE_LEN = 4;
`ifdef DPSK_TX_PREAMBLE_EN
    localparam int PRE_SYMS = PREAMBLE_LEN;
`else
    localparam int PRE_SYMS = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, dpsk_tx_data, dpsk_tx_raw, dpsk_tx_strobe, tx_busy;

    always #5 sys_clk = ~sys_clk;

    dpsk_bit_tx #(
        .BIT_DIV      (BIT_DIV),
        .PREAMBLE_LEN (PREAMBLE_LEN)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .dpsk_tx_data   (dpsk_tx_data),
        .dpsk_tx_raw    (dpsk_tx_raw),
        .dpsk_tx_strobe (dpsk_tx_strobe),
        .tx_busy        (tx_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining busy cycles and queue of raw bits still to be sent
    int  m_remain = 0;
    bit  m_known  = 1'b0;
    bit  m_ref    = 1'b0;
    bit  m_raw    = 1'b0;
    bit  m_syms[$];
    bit  last_hs  = 1'b0;

    int          n_strobe = 0;
    logic [15:0] cap_raw  = '0;
    logic [15:0] cap_data = '0;

    logic       drv_rst   = 1'b1;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data  = 8'h00;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_raw;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit exp_ready, exp_strobe, b, hs;
        int len;
        exp_ready = !rst && (m_remain <= 1);
        if (rst || m_known) chk("tx_ready", tx_ready, exp_ready);
        if (m_known) begin
            exp_strobe = (m_remain > 0) && (m_remain % BIT_DIV == 0);
            if (exp_strobe && m_syms.size() > 0) begin
                b      = m_syms.pop_front();
                m_raw  = b;
                m_ref  = m_ref ^ b;
            end
            chk("strobe", dpsk_tx_strobe, exp_strobe);
            chk("busy", tx_busy, m_remain > 0);
            chk("raw", dpsk_tx_raw, m_raw);
            chk("data", dpsk_tx_data, m_ref);
        end
        if (dpsk_tx_strobe === 1'b1) begin
            n_strobe++;
            cap_raw  = {cap_raw[14:0], dpsk_tx_raw};
            cap_data = {cap_data[14:0], dpsk_tx_data};
        end
        hs      = tx_valid && exp_ready;
        last_hs = hs;
        if (rst) begin
            m_remain = 0;
            m_syms.delete();
            m_ref    = 1'b0;
            m_raw    = 1'b0;
            m_known  = 1'b1;
        end else begin
            len = 0;
            if (hs) begin
                if (m_remain == 0) begin
                    for (int i = 0; i < PRE_SYMS; i++) m_syms.push_back(1'b1);
                    len = PRE_SYMS * BIT_DIV;
                end
                for (int i = 7; i >= 0; i--) m_syms.push_back(tx_data[i]);
                len += 8 * BIT_DIV;
            end
            m_remain = ((m_remain > 0) ? m_remain - 1 : 0) + len;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        rst      = drv_rst;
        tx_valid = drv_valid;
        tx_data  = drv_data;
        @(negedge sys_clk);
        monitor();
    endtask

    task automatic do_reset(input int n);
        drv_rst   = 1'b1;
        drv_valid = 1'b0;
        repeat (n) step();
        drv_rst = 1'b0;
    endtask

    task automatic clr_cap();
        n_strobe = 0;
        cap_raw  = '0;
        cap_data = '0;
    endtask

    task automatic wait_accept(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!last_hs && k < 400);
        chk("accept", last_hs, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        drv_valid = 1'b1;
        drv_data  = b;
        wait_accept(k);
        drv_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            step();
            k++;
        end while ((tx_busy || m_remain != 0) && k < 400);
        chk("idle_reached", tx_busy, 1'b0);
    endtask

    task automatic wait_strobes(input int n);
        int k = 0;
        while (n_strobe < n && k < 400) begin
            step();
            k++;
        end
        chk("strobe_wait", n_strobe, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{8'hA5, 8'hA5, 8'hC6};
        vecs[1] = '{8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF, 8'hAA};
        vecs[3] = '{8'h80, 8'h80, 8'hFF};
        vecs[4] = '{8'h3C, 8'h3C, 8'h28};
        vecs[5] = '{8'h01, 8'h01, 8'h01};

        // Reset held for 5 cycles, then released
        drv_rst = 1'b1;
        repeat (5) step();
        drv_rst = 1'b0;
        step();
        chk("rel_ready", tx_ready, 1'b1);
        chk("rel_data", dpsk_tx_data, 1'b0);
        chk("rel_raw", dpsk_tx_raw, 1'b0);
        chk("rel_strobe", dpsk_tx_strobe, 1'b0);
        chk("rel_busy", tx_busy, 1'b0);

        // Single bytes from reset state
        for (int i = 0; i < 6; i++) begin
            do_reset(2);
            clr_cap();
            send_byte(vecs[i].din);
            wait_idle();
            chk($sformatf("vec%0d_strobes", i), n_strobe, PRE_SYMS + 8);
            chk($sformatf("vec%0d_raw", i), cap_raw[7:0], vecs[i].exp_raw);
            chk($sformatf("vec%0d_data", i), cap_data[7:0], vecs[i].exp_data);
        end

        // Back-to-back 0x00 then 0xFF with tx_valid held
        do_reset(2);
        clr_cap();
        drv_valid = 1'b1;
        drv_data  = 8'h00;
        wait_accept(k);
        drv_data = 8'hFF;
        wait_accept(k);
        chk("b2b_gapless", k, 8 * BIT_DIV + PRE_SYMS * BIT_DIV);
        drv_valid = 1'b0;
        wait_idle();
        chk("b2b_strobes", n_strobe, PRE_SYMS + 16);
        chk("b2b_raw", cap_raw, 16'h00FF);
        chk("b2b_data", cap_data, 16'h00AA);

        // Reset after the 3rd strobe of 0xFF, then 0x80
        do_reset(2);
        clr_cap();
        send_byte(8'hFF);
        wait_strobes(3);
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        step();
        chk("mid_rst_data", dpsk_tx_data, 1'b0);
        chk("mid_rst_raw", dpsk_tx_raw, 1'b0);
        chk("mid_rst_busy", tx_busy, 1'b0);
        repeat (12) step();
        chk("mid_rst_no_strobe", n_strobe, 3);
        clr_cap();
        send_byte(8'h80);
        wait_idle();
        chk("mid_rst_0x80_data", cap_data[7:0], 8'hFF);

        // Backpressure: 0x3C offered during the 2nd symbol of 0xA5
        do_reset(2);
        clr_cap();
        send_byte(8'hA5);
        wait_strobes(2);
        drv_valid = 1'b1;
        drv_data  = 8'h3C;
        wait_accept(k);
        drv_valid = 1'b0;
        chk("bp_wait", k, (PRE_SYMS + 8) * BIT_DIV - BIT_DIV - 1);
        wait_idle();
        chk("bp_strobes", n_strobe, PRE_SYMS + 16);
        chk("bp_raw", cap_raw, 16'hA53C);

`ifdef DPSK_TX_PREAMBLE_EN
        // Preamble toggles from the held reference of the previous burst
        do_reset(2);
        clr_cap();
        send_byte(8'h00);
        wait_idle();
        chk("pre_data0", cap_data[11:0], 12'hA00);
        send_byte(8'h01);
        wait_idle();
        clr_cap();
        send_byte(8'h00);
        wait_idle();
        chk("pre_data1", cap_data[11:0], 12'h5FF);
`endif

        // Random traffic with sparse resets
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            drv_rst   = ($urandom_range(0, 299) == 0);
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_data  = 8'($urandom);
            step();
        end
        drv_rst   = 1'b0;
        drv_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
